alu_wb_stage: RTL

ALU_WB_STAGE -- requirements
Module: alu_wb_stage

---
 rtl/alu_wb_stage.sv | 135 +++++++++++++
 1 files changed

// File: rtl/alu_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_wb_stage
//  Description : ALU issue / write-back stage. Sequences single-cycle and
//                multi-cycle (mul/div) ALU operations, registers the result
//                into the register-file write port and counts upstream
//                stall cycles (saturating).
//                Optional macro ALU_WB_FWD_EN enables the forwarding outputs
//                (registered copy of the write-back port); otherwise the
//                forwarding outputs are tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_wb_stage #(
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         in_sel,
  input  logic [4:0]         in_rd,
  input  logic               in_we,
  output logic [4:0]         alu_sel,
  input  logic [31:0]        alu_dataD,
  input  logic               alu_ready,
  output logic               wb_we,
  output logic [4:0]         wb_rd,
  output logic [31:0]        wb_data,
  output logic               fwd_valid,
  output logic [4:0]         fwd_rd,
  output logic [31:0]        fwd_data,
  output logic [STALL_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MULBUSY = 2'd1,
    BUBBLE  = 2'd2
  } state_t;

  localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic               capture_d;
  logic               wb_we_q;
  logic [4:0]         wb_rd_q;
  logic [31:0]        wb_data_q;
  logic [STALL_W-1:0] stall_q;

  // State register; reset discards any in-flight mul/div operation
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state, handshake and ALU select decode
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    capture_d = 1'b0;
    alu_sel   = in_sel;
    case (state_q)
      IDLE: begin
        if (in_valid && !in_sel[4]) begin
          in_ready  = 1'b1;
          capture_d = 1'b1;
        end else if (in_valid && in_sel[4]) begin
          // Entering mul/div: a done flag left over from a prior op is ignored
          state_d = MULBUSY;
        end
      end
      MULBUSY: begin
        if (!in_valid || !in_sel[4]) begin
          // Upstream withdrew the op: abort without capture
          state_d = IDLE;
        end else if (alu_ready) begin
          in_ready  = 1'b1;
          capture_d = 1'b1;
          state_d   = BUBBLE;
        end
      end
      BUBBLE: begin
        // Force bit 4 low for one cycle so the ALU sees a fresh start
        alu_sel = 5'h00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!rst) begin
      in_ready  = 1'b0;
      capture_d = 1'b0;
    end
  end

  // Write-back port: index/data load on capture and hold, strobe is one cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_we_q   <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= 32'd0;
    end else begin
      wb_we_q <= capture_d && in_we && (in_rd != 5'd0);
      if (capture_d) begin
        wb_rd_q   <= in_rd;
        wb_data_q <= alu_dataD;
      end
    end
  end

  // Saturating count of cycles where upstream is waiting on this stage
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (in_valid && !in_ready && !(&stall_q)) begin
      stall_q <= stall_q + STALL_ONE;
    end
  end

  assign wb_we       = wb_we_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign stall_count = stall_q;

`ifdef ALU_WB_FWD_EN
  assign fwd_valid = wb_we_q;
  assign fwd_rd    = wb_rd_q;
  assign fwd_data  = wb_data_q;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = 5'd0;
  assign fwd_data  = 32'd0;
`endif

endmodule
`default_nettype wire
